lcd_cmd_sched: RTL and testbench
================================

Name: lcd_cmd_sched

Overview:
- Command buffer and scheduler between the core's LCD I/O register (o_io_lcd / o_lcd_vld) and lcd_ctrl (i_vld / o_rdy).
- Queues LCD command words written by software into a FIFO and enforces the HD44780 power-on delay.
- After each command it enforces the per-command execution delay (short for most commands, long for Clear Display / Return Home), so firmware need not poll the busy flag.
- Presents one command at a time to lcd_ctrl with a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- T_PERIOD_NS, 40, clock period in ns.
- T_INIT_NS, 40_000_000, post-reset quiet time before the first command.
- T_EXEC_NS, 40_000, wait after an ordinary command.
- T_EXEC_LONG_NS, 1_640_000, wait after Clear Display / Return Home.
- Derived cycle counts: INIT_CYC, EXEC_CYC and LONG_CYC = ceil(T_x_NS / T_PERIOD_NS), each minimum 1.
- Counter width = clog2(max cycle count + 1).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_vld  in  1  one command write per cycle high, from the core.
- i_cmd  in  32  command word: bit31 LCD_ON, bit9 RS, bit8 RW, bits[7:0] DATA; other bits are carried through.
- o_vld  out  1  command valid to lcd_ctrl.
- o_cmd  out  32  command word to lcd_ctrl.
- i_rdy  in  1  lcd_ctrl ready.
- o_full  out  1  FIFO full.
- o_level  out  clog2(DEPTH)+1  FIFO occupancy.
- o_ovf  out  1  sticky overflow flag (a write was dropped).
- o_busy  out  1  high while not IDLE or FIFO not empty.

Behaviour:
- Reset (i_rst_n low at an i_clk edge): FIFO pointers and level go to 0, state goes to S_INIT, init counter loads INIT_CYC-1. Reset may occur mid-operation; any in-flight command is discarded.
- Output reset values: o_vld=0, o_cmd=0, o_full=0, o_level=0, o_ovf=0, o_busy=1 (state is S_INIT).
- FIFO write: i_vld high at an edge writes i_cmd if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the write is dropped and o_ovf is set.
  - o_ovf clears only on reset.
- FIFO read: a pop occurs only on the handshake cycle (o_vld & i_rdy).
  - Simultaneous push and pop leaves o_level unchanged.
  - Pointers wrap modulo DEPTH.
- o_cmd equals the FIFO head while o_vld=1, else 0. It must stay stable until the handshake.
- o_vld = (state == S_SEND). It must never drop without a handshake.
- State machine:
  - S_INIT: count down the init counter; at 0 go to S_IDLE. The FIFO accepts writes during S_INIT. o_vld stays 0.
  - S_IDLE: if level>0, go to S_SEND next edge.
  - S_SEND: on o_vld & i_rdy, pop and load the wait counter with WAIT-1, then go to S_WAIT.
    - WAIT = LONG_CYC if RS=0, RW=0 and DATA ∈ {0x01, 0x02, 0x03}; else EXEC_CYC.
    - Reads (RW=1) use EXEC_CYC.
  - S_WAIT: decrement; at 0 go to S_IDLE. S_WAIT lasts exactly WAIT cycles.
- Latency:
  - From S_IDLE with the FIFO empty, o_vld rises in the 2nd cycle after the i_vld sampling edge.
  - Back-to-back commands: the next o_vld rises WAIT+1 cycles after the previous handshake cycle (one S_IDLE cycle).
- i_rdy is ignored outside S_SEND.
- o_full = (level == DEPTH).

Test Plan (DEPTH=4, T_PERIOD_NS=40, T_INIT_NS=400 → 10 cycles, T_EXEC_NS=200 → 5, T_EXEC_LONG_NS=800 → 20; i_rdy tied 1 unless stated):
- Init hold: push 0x8000_0238 at cycle 2 after reset release → o_vld stays 0 through S_INIT (10 cycles), then rises one cycle after S_IDLE is entered with o_cmd=0x8000_0238; o_level returns to 0 after the handshake.
- Short vs long wait: push 0x8000_0038, 0x8000_0001, 0x8000_0241 back-to-back.
  - 2nd o_vld rises 6 cycles after the 1st handshake.
  - 3rd o_vld rises 21 cycles after the 2nd handshake.
  - RS=1 data 0x01 must use the short wait.
- Backpressure: i_rdy=0 for 7 cycles during S_SEND → o_vld and o_cmd are held constant, no pop occurs and o_level is unchanged; the pop happens on the first cycle with i_rdy=1.
- Overflow: with i_rdy=0, push 5 words → o_full=1 after the 4th push, the 5th is dropped and o_ovf=1.
  - Release i_rdy → exactly the 4 stored words emerge in order.
  - o_ovf remains 1.
- Push+pop when full: with the FIFO full, push on the same cycle as a handshake → the write is accepted, o_level stays 4 and o_ovf does not set.
- Reset mid-operation: assert i_rst_n=0 for 1 cycle during S_WAIT with 3 words queued → the next edge gives o_level=0, o_vld=0, o_ovf=0, state S_INIT, and the full 10-cycle init delay is re-applied.

Source files
------------

// File: rtl/lcd_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// lcd_cmd_sched_if : core-side write port and lcd_ctrl-side handshake of the
//                    LCD command scheduler.            Revision: 1.0
// ============================================================================
interface lcd_cmd_sched_if #(
    parameter int DEPTH = 8
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          i_vld;
    logic [31:0]   i_cmd;
    logic          o_vld;
    logic [31:0]   o_cmd;
    logic          i_rdy;
    logic          o_full;
    logic [LW-1:0] o_level;
    logic          o_ovf;
    logic          o_busy;

    modport slave (
        input  i_vld, i_cmd, i_rdy,
        output o_vld, o_cmd, o_full, o_level, o_ovf, o_busy
    );

    modport master (
        output i_vld, i_cmd, i_rdy,
        input  o_vld, o_cmd, o_full, o_level, o_ovf, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_sched.sv
`default_nettype none
// ============================================================================
// lcd_cmd_sched : command FIFO plus power-on / per-command delay scheduler
//                 in front of lcd_ctrl.                Revision: 1.0
// ============================================================================
module lcd_cmd_sched #(
    parameter int DEPTH          = 8,
    parameter int T_PERIOD_NS    = 40,
    parameter int T_INIT_NS      = 40_000_000,
    parameter int T_EXEC_NS      = 40_000,
    parameter int T_EXEC_LONG_NS = 1_640_000
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    lcd_cmd_sched_if.slave   bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    localparam int INIT_RAW = (T_INIT_NS + T_PERIOD_NS - 1) / T_PERIOD_NS;
    localparam int EXEC_RAW = (T_EXEC_NS + T_PERIOD_NS - 1) / T_PERIOD_NS;
    localparam int LONG_RAW = (T_EXEC_LONG_NS + T_PERIOD_NS - 1) / T_PERIOD_NS;
    localparam int INIT_CYC = (INIT_RAW < 1) ? 1 : INIT_RAW;
    localparam int EXEC_CYC = (EXEC_RAW < 1) ? 1 : EXEC_RAW;
    localparam int LONG_CYC = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int MAX_A    = (INIT_CYC > EXEC_CYC) ? INIT_CYC : EXEC_CYC;
    localparam int MAX_CYC  = (MAX_A > LONG_CYC) ? MAX_A : LONG_CYC;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD = CNT_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic [31:0]      mem_q [DEPTH];

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_head;
    logic             w_long;

    assign w_full = (level_q == LW'(DEPTH));
    assign w_pop  = (state_q == S_SEND) & bus.i_rdy;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_push = bus.i_vld & (~w_full | w_pop);
    assign w_head = mem_q[rd_ptr_q];
    assign w_long = ~w_head[9] & ~w_head[8] &
                    ((w_head[7:0] == 8'h01) | (w_head[7:0] == 8'h02) |
                     (w_head[7:0] == 8'h03));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.i_cmd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (bus.i_vld & ~w_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= INIT_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One down-counter serves both the power-on quiet time and the
    // post-command execution delay; the two phases never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.i_rdy) begin
                    state_d = S_WAIT;
                    cnt_d   = w_long ? LONG_LD : EXEC_LD;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = INIT_LD;
            end
        endcase
    end

    assign bus.o_vld   = (state_q == S_SEND);
    assign bus.o_cmd   = (state_q == S_SEND) ? w_head : 32'h0;
    assign bus.o_full  = w_full;
    assign bus.o_level = level_q;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_busy  = (state_q != S_IDLE) | (level_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sched.sv
`default_nettype none
// ============================================================================
// tb_lcd_cmd_sched : directed vectors, timing sequences and a timestamp-based
//                    reference model for lcd_cmd_sched.  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_cmd_sched;
    localparam int DEPTH    = 4;
    localparam int INIT_CYC = 10;   // 400 ns / 40 ns
    localparam int EXEC_CYC = 5;    // 200 ns / 40 ns
    localparam int LONG_CYC = 20;   // 800 ns / 40 ns

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #20 clk = ~clk;

    lcd_cmd_sched_if #(.DEPTH(DEPTH)) bus ();

    lcd_cmd_sched #(
        .DEPTH          (DEPTH),
        .T_PERIOD_NS    (40),
        .T_INIT_NS      (400),
        .T_EXEC_NS      (200),
        .T_EXEC_LONG_NS (800)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.o_busy && k < 300) begin
            cyc();
            k++;
        end
        if (bus.o_busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: o_busy still 1 after %0d cycles", k);
        end
    endtask

    task automatic wait_vld();
        int k = 0;
        while (!bus.o_vld && k < 300) begin
            cyc();
            k++;
        end
        if (!bus.o_vld) begin
            total++;
            bad++;
            $display("FAIL vld_timeout: o_vld still 0 after %0d cycles", k);
        end
    endtask

    // Reference model: a queue of commands plus the absolute edge index from
    // which a new command may be presented (set by reset and by each handshake).
    logic [31:0] mq[$];
    bit          m_vld   = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_known = 1'b0;
    int          ecount  = 0;
    int          avail   = 0;

    function automatic bit is_long(input logic [31:0] c);
        return (c[9] == 1'b0) && (c[8] == 1'b0) && (c[7:0] >= 8'd1) && (c[7:0] <= 8'd3);
    endfunction

    initial begin : p_model
        int          sz;
        bit          was;
        bit          pop;
        logic [31:0] head;
        forever begin
            @(posedge clk);
            ecount++;
            if (!rst_n) begin
                mq.delete();
                m_vld   = 1'b0;
                m_ovf   = 1'b0;
                avail   = ecount + INIT_CYC + 1;
                m_known = 1'b1;
            end else if (m_known) begin
                sz  = mq.size();
                was = m_vld;
                pop = was && bus.i_rdy;
                if (pop) begin
                    head  = mq.pop_front();
                    avail = ecount + (is_long(head) ? LONG_CYC : EXEC_CYC) + 1;
                end
                if (bus.i_vld) begin
                    if (sz < DEPTH || pop) mq.push_back(bus.i_cmd);
                    else                   m_ovf = 1'b1;
                end
                if (was) m_vld = !pop;
                else     m_vld = (ecount >= avail) && (sz > 0);
            end
        end
    end

    initial begin : p_scoreboard
        logic [63:0] act;
        logic [63:0] exp;
        bit          m_idle;
        forever begin
            @(negedge clk);
            if (m_known) begin
                m_idle = !m_vld && (ecount >= avail - 1);
                exp = {25'd0, m_vld, (m_vld ? mq[0] : 32'h0), 3'(mq.size()),
                       (mq.size() == DEPTH), m_ovf, (!m_idle || mq.size() > 0)};
                act = {25'd0, bus.o_vld, bus.o_cmd, bus.o_level,
                       bus.o_full, bus.o_ovf, bus.o_busy};
                chk("model{vld,cmd,lvl,full,ovf,busy}", act, exp);
            end
        end
    end

    typedef struct {
        logic [31:0] cmd;
        int          gap;   // cycles from handshake edge to next o_vld rise
    } gap_vec_t;

    gap_vec_t    gv[10];
    logic [31:0] words[5];
    logic [31:0] rc;
    int          n;

    initial begin : p_main
        gv[0] = '{32'h8000_0038, EXEC_CYC + 1};
        gv[1] = '{32'h8000_0001, LONG_CYC + 1};
        gv[2] = '{32'h8000_0241, EXEC_CYC + 1};   // RS=1 data write
        gv[3] = '{32'h8000_0002, LONG_CYC + 1};
        gv[4] = '{32'h8000_0003, LONG_CYC + 1};
        gv[5] = '{32'h8000_0004, EXEC_CYC + 1};
        gv[6] = '{32'h8000_0101, EXEC_CYC + 1};   // RW=1 read
        gv[7] = '{32'h0000_0000, EXEC_CYC + 1};
        gv[8] = '{32'h0000_0C01, LONG_CYC + 1};   // carried bits do not matter
        gv[9] = '{32'h8000_0301, EXEC_CYC + 1};

        bus.i_vld = 1'b0;
        bus.i_cmd = 32'h0;
        bus.i_rdy = 1'b1;
        rst_n     = 1'b0;
        cyc();
        cyc();
        chk("reset{vld,cmd,lvl,full,ovf,busy}",
            {bus.o_vld, bus.o_cmd, bus.o_level, bus.o_full, bus.o_ovf, bus.o_busy},
            {1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1});

        // Init hold: push two edges after the last reset edge.
        rst_n = 1'b1;
        cyc();
        bus.i_vld = 1'b1;
        bus.i_cmd = 32'h8000_0238;
        cyc();
        bus.i_vld = 1'b0;
        n = 2;
        while (!bus.o_vld && n < 60) begin
            cyc();
            n++;
        end
        chk("init_rise_edge", n, INIT_CYC + 1);
        chk("init_cmd", bus.o_cmd, 32'h8000_0238);
        cyc();
        chk("init_pop{vld,lvl}", {bus.o_vld, bus.o_level}, {1'b0, 3'd0});

        // Wait-length classification table.
        for (int i = 0; i < 10; i++) begin
            wait_idle();
            bus.i_vld = 1'b1;
            bus.i_cmd = gv[i].cmd;
            cyc();
            bus.i_cmd = 32'h8000_0006;
            cyc();
            bus.i_vld = 1'b0;
            wait_vld();
            chk($sformatf("gap_cmd[%0d]", i), bus.o_cmd, gv[i].cmd);
            n = 0;
            do begin
                cyc();
                n++;
            end while (!bus.o_vld && n < 100);
            chk($sformatf("gap_len[%0d]", i), n - 1, gv[i].gap);
        end

        // Backpressure: 7 cycles of i_rdy=0 while presenting.
        wait_idle();
        bus.i_rdy = 1'b0;
        bus.i_vld = 1'b1;
        bus.i_cmd = 32'h8000_00C0;
        cyc();
        bus.i_vld = 1'b0;
        wait_vld();
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk($sformatf("bp_hold[%0d]{vld,cmd,lvl}", i),
                {bus.o_vld, bus.o_cmd, bus.o_level}, {1'b1, 32'h8000_00C0, 3'd1});
        end
        bus.i_rdy = 1'b1;
        cyc();
        chk("bp_pop{vld,lvl}", {bus.o_vld, bus.o_level}, {1'b0, 3'd0});

        // Push coinciding with a pop while full.
        wait_idle();
        bus.i_rdy = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = 32'h8000_0010 + 32'(i);
        bus.i_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_cmd = words[i];
            cyc();
        end
        chk("pf_full{full,lvl,ovf}", {bus.o_full, bus.o_level, bus.o_ovf}, {1'b1, 3'd4, 1'b0});
        bus.i_rdy = 1'b1;
        bus.i_cmd = words[4];
        cyc();
        bus.i_vld = 1'b0;
        chk("pf_pushpop{full,lvl,ovf}", {bus.o_full, bus.o_level, bus.o_ovf}, {1'b1, 3'd4, 1'b0});
        for (int i = 1; i < 5; i++) begin
            wait_vld();
            chk($sformatf("pf_order[%0d]", i), bus.o_cmd, words[i]);
            cyc();
        end

        // Overflow: fifth write into a full FIFO is dropped.
        wait_idle();
        bus.i_rdy = 1'b0;
        bus.i_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            words[i]  = 32'h8000_0020 + 32'(i);
            bus.i_cmd = words[i];
            cyc();
            if (i == 3)
                chk("ovf_full4{full,lvl,ovf}", {bus.o_full, bus.o_level, bus.o_ovf},
                    {1'b1, 3'd4, 1'b0});
        end
        bus.i_vld = 1'b0;
        chk("ovf_drop{full,lvl,ovf}", {bus.o_full, bus.o_level, bus.o_ovf}, {1'b1, 3'd4, 1'b1});
        bus.i_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_vld();
            chk($sformatf("ovf_order[%0d]", i), bus.o_cmd, words[i]);
            cyc();
        end
        wait_idle();
        chk("ovf_sticky{lvl,ovf}", {bus.o_level, bus.o_ovf}, {3'd0, 1'b1});

        // Reset during the wait phase with three words still queued.
        bus.i_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_cmd = 32'h8000_0030 + 32'(i);
            cyc();
        end
        bus.i_vld = 1'b0;
        chk("rst_pre{vld,lvl}", {bus.o_vld, bus.o_level}, {1'b0, 3'd3});
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid{vld,lvl,full,ovf,busy}",
            {bus.o_vld, bus.o_level, bus.o_full, bus.o_ovf, bus.o_busy},
            {1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
        bus.i_vld = 1'b1;
        bus.i_cmd = 32'h8000_000C;
        cyc();
        bus.i_vld = 1'b0;
        n = 1;
        while (!bus.o_vld && n < 60) begin
            cyc();
            n++;
        end
        chk("rst_reinit_edge", n, INIT_CYC + 1);
        chk("rst_reinit_cmd", bus.o_cmd, 32'h8000_000C);

        // Randomized traffic; the scoreboard checks every cycle.
        for (int c = 0; c < 5000; c++) begin
            rst_n     = ($urandom_range(0, 599) != 0);
            bus.i_vld = ($urandom_range(0, 99) < 35);
            rc        = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                rc[9:8] = 2'($urandom_range(0, 3));
                rc[7:0] = 8'($urandom_range(0, 4));
            end
            bus.i_cmd = rc;
            bus.i_rdy = ($urandom_range(0, 99) < 70);
            cyc();
        end
        rst_n     = 1'b1;
        bus.i_vld = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
